// File: rtl/pio_sm_ctrl.sv
// ---------------------------------------------------------------------------
// pio_sm_ctrl
//
// Host-facing control block for a bank of PIO state machines. It holds the
// per-machine enable, restart pulse and clock divisor, the shared IRQ flags
// and the IRQ mask. It can also inject one host "immediate" instruction into
// a single machine at a time, using a small IDLE/ISSUE/DONE handshake.
//
// Optional feature macro: PIO_SM_CTRL_EXEC_EN
//   defined     -> EXEC register and injection FSM are present
//   not defined -> sm_imm/imm_instr tie to 0, EXEC writes are ignored,
//                  EXEC and STATUS busy/EXEC_OVF read 0
//
// Ports
//   clk, reset     system clock; synchronous active-high reset
//   wr_en/addr/data  host register write (word address 0..7)
//   rd_addr/rd_data  host register read, rd_data registered (1-cycle latency)
//   sm_penable     per-machine divided-clock enable
//   sm_stalled     per-machine stall indication
//   irq_set/clr    OR of machine IRQ set/clear strobes
//   sm_en          machine enable (CTRL EN, forced on while injecting)
//   sm_restart     one-cycle restart pulse per machine
//   sm_div         packed 24-bit divisors, machine n at [24n+23:24n]
//   sm_imm         immediate-instruction select, one-hot
//   imm_instr      instruction being injected
//   irq_flags      shared IRQ flags
//   irq_out        host interrupt, |(irq_flags[3:0] & IRQ_MASK)
//
// Register map
//   0 CTRL    [3:0] EN, [7:4] RESTART (write-1 pulse, reads 0)
//   1 IRQ     [7:0] flags (W1C), [11:8] IRQ_MASK
//   2 EXEC    [15:0] instr, [17:16] target
//   3 STATUS  [0] busy, [7:4] sm_stalled, [8] EXEC_OVF (W1C)
//   4..7      CLKDIV_n [23:0]
// ---------------------------------------------------------------------------
module pio_sm_ctrl #(
    parameter int NUM_SM = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [2:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [2:0]           rd_addr,
    output logic [31:0]          rd_data,
    input  logic [NUM_SM-1:0]    sm_penable,
    input  logic [NUM_SM-1:0]    sm_stalled,
    input  logic [7:0]           irq_set,
    input  logic [7:0]           irq_clr,
    output logic [NUM_SM-1:0]    sm_en,
    output logic [NUM_SM-1:0]    sm_restart,
    output logic [24*NUM_SM-1:0] sm_div,
    output logic [NUM_SM-1:0]    sm_imm,
    output logic [15:0]          imm_instr,
    output logic [7:0]           irq_flags,
    output logic                 irq_out
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_IRQ    = 3'd1;
    localparam logic [2:0] A_EXEC   = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;

    // -----------------------------------------------------------------------
    // Write decode
    // -----------------------------------------------------------------------
    logic wr_ctrl, wr_irq, wr_exec, wr_status;

    assign wr_ctrl   = wr_en && (wr_addr == A_CTRL);
    assign wr_irq    = wr_en && (wr_addr == A_IRQ);
    assign wr_exec   = wr_en && (wr_addr == A_EXEC);
    assign wr_status = wr_en && (wr_addr == A_STATUS);

    // -----------------------------------------------------------------------
    // Configuration / flag registers
    // -----------------------------------------------------------------------
    logic [NUM_SM-1:0]       en_q, en_d;
    logic [NUM_SM-1:0]       restart_q, restart_d;
    logic [NUM_SM-1:0][23:0] div_q, div_d;
    logic [3:0]              mask_q, mask_d;
    logic [7:0]              flags_q, flags_d;
    logic [31:0]             rd_data_q, rd_data_d;

    always_comb begin
        en_d      = en_q;
        mask_d    = mask_q;
        div_d     = div_q;
        restart_d = '0;
        if (wr_ctrl) begin
            en_d      = wr_data[NUM_SM-1:0];
            restart_d = wr_data[4 +: NUM_SM];
        end
        if (wr_irq) begin
            mask_d = wr_data[11:8];
        end
        for (int n = 0; n < NUM_SM; n++) begin
            if (wr_en && (wr_addr == 3'(4 + n))) begin
                div_d[n] = wr_data[23:0];
            end
        end
        // Set wins over both the host W1C and the machine clear strobes.
        flags_d = (flags_q & ~(wr_irq ? wr_data[7:0] : 8'd0) & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= '0;
            restart_q <= '0;
            div_q     <= {NUM_SM{24'd1}};
            mask_q    <= '0;
            flags_q   <= '0;
            rd_data_q <= '0;
        end else begin
            en_q      <= en_d;
            restart_q <= restart_d;
            div_q     <= div_d;
            mask_q    <= mask_d;
            flags_q   <= flags_d;
            rd_data_q <= rd_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Immediate-instruction injection
    // -----------------------------------------------------------------------
    logic [NUM_SM-1:0] imm_sel;
    logic [15:0]       imm_word;
    logic              busy;
    logic              exec_ovf;
    logic [31:0]       exec_rd;

`ifdef PIO_SM_CTRL_EXEC_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [1:0]        tgt_q, tgt_d;
    logic              ovf_q, ovf_d;
    logic [NUM_SM-1:0] tgt_oh;
    logic              tgt_ok;
    logic              go;
    logic              abort;

    assign tgt_oh = NUM_SM'(1) << tgt_q;
    assign tgt_ok = ({30'd0, wr_data[17:16]} < 32'(NUM_SM));
    // Injection completes on the first penable where the target is not stalled.
    assign go     = |(sm_penable & ~sm_stalled & tgt_oh);
    // Restarting the target machine cancels a pending injection.
    assign abort  = wr_ctrl && |(wr_data[4 +: NUM_SM] & tgt_oh);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            tgt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            tgt_q   <= tgt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        tgt_d   = tgt_q;
        ovf_d   = ovf_q & ~(wr_status && wr_data[8]);
        case (state_q)
            S_IDLE: begin
                if (wr_exec) begin
                    if (tgt_ok) begin
                        state_d = S_ISSUE;
                        instr_d = wr_data[15:0];
                        tgt_d   = wr_data[17:16];
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (wr_exec) ovf_d = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (go) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (wr_exec) ovf_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imm_sel  = '0;
        imm_word = '0;
        if (state_q == S_ISSUE) begin
            imm_sel  = tgt_oh;
            imm_word = instr_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign exec_ovf = ovf_q;
    assign exec_rd  = {16'd0, instr_q};
`else
    assign imm_sel  = '0;
    assign imm_word = '0;
    assign busy     = 1'b0;
    assign exec_ovf = 1'b0;
    assign exec_rd  = '0;
`endif

    // -----------------------------------------------------------------------
    // Read mux (registered)
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            A_CTRL:   rd_data_d = {28'd0, 4'(en_q)};
            A_IRQ:    rd_data_d = {20'd0, mask_q, flags_q};
            A_EXEC:   rd_data_d = exec_rd;
            A_STATUS: rd_data_d = {23'd0, exec_ovf, 4'(sm_stalled), 3'd0, busy};
            default: begin
                for (int n = 0; n < NUM_SM; n++) begin
                    if (rd_addr == 3'(4 + n)) rd_data_d = {8'd0, div_q[n]};
                end
            end
        endcase
    end

    // Not every write-data bit maps to a register field.
    logic unused_ok;
    assign unused_ok = ^{wr_data, sm_penable, sm_stalled};

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The injection force-enable overrides a concurrent EN clear.
    assign sm_en      = en_q | imm_sel;
    assign sm_restart = restart_q;
    assign sm_div     = div_q;
    assign sm_imm     = imm_sel;
    assign imm_instr  = imm_word;
    assign irq_flags  = flags_q;
    assign irq_out    = |(flags_q[3:0] & mask_q);
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_pio_sm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pio_sm_ctrl: directed, self-checking bench for pio_sm_ctrl (NUM_SM=4).
// Inputs change and outputs are sampled just after the falling edge; the DUT
// samples on the rising edge. Register reads push the expected value into a
// scoreboard queue and pop it once rd_data is valid one cycle later.
// ---------------------------------------------------------------------------
module tb_pio_sm_ctrl;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [2:0]     wr_addr;
    logic [31:0]    wr_data;
    logic [2:0]     rd_addr;
    logic [31:0]    rd_data;
    logic [N-1:0]   sm_penable;
    logic [N-1:0]   sm_stalled;
    logic [7:0]     irq_set;
    logic [7:0]     irq_clr;
    logic [N-1:0]   sm_en;
    logic [N-1:0]   sm_restart;
    logic [24*N-1:0] sm_div;
    logic [N-1:0]   sm_imm;
    logic [15:0]    imm_instr;
    logic [7:0]     irq_flags;
    logic           irq_out;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pio_sm_ctrl #(.NUM_SM(N)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .sm_penable(sm_penable), .sm_stalled(sm_stalled),
        .irq_set(irq_set), .irq_clr(irq_clr),
        .sm_en(sm_en), .sm_restart(sm_restart), .sm_div(sm_div),
        .sm_imm(sm_imm), .imm_instr(imm_instr),
        .irq_flags(irq_flags), .irq_out(irq_out)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    // Read: expected value is queued when the address is driven and compared
    // against rd_data when it becomes valid.
    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
        logic [31:0] ev;
        string       tv;
        rd_addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        ev = exp_q.pop_front();
        tv = tag_q.pop_front();
        chk(tv, {64'd0, rd_data}, {64'd0, ev});
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        sm_penable = '0; sm_stalled = '0; irq_set = '0; irq_clr = '0;
        tick(); tick();

        // Reset state
        chk("rst_rd_data",   rd_data,    0);
        chk("rst_sm_en",     sm_en,      0);
        chk("rst_restart",   sm_restart, 0);
        chk("rst_sm_div",    sm_div,     {4{24'd1}});
        chk("rst_sm_imm",    sm_imm,     0);
        chk("rst_imm_instr", imm_instr,  0);
        chk("rst_irq_flags", irq_flags,  0);
        chk("rst_irq_out",   irq_out,    0);
        reset = 1'b0;
        rd(3'd0, 32'h0, "rd_ctrl_rst");
        rd(3'd1, 32'h0, "rd_irq_rst");
        rd(3'd2, 32'h0, "rd_exec_rst");
        rd(3'd3, 32'h0, "rd_status_rst");
        for (int n = 0; n < 4; n++) rd(3'(4 + n), 32'h1, "rd_clkdiv_rst");

        // CTRL: enable 0 and 2, restart 1
        wr(3'd0, 32'h0000_0025);
        chk("ctrl_en",        sm_en,      4'b0101);
        chk("ctrl_restart",   sm_restart, 4'b0010);
        tick();
        chk("ctrl_restart_1c", sm_restart, 4'b0000);
        rd(3'd0, 32'h5, "rd_ctrl");

        // CLKDIV
        wr(3'd5, 32'hFF12_3456);
        chk("div1_out", sm_div[47:24], 24'h123456);
        chk("div0_out", sm_div[23:0],  24'h1);
        rd(3'd5, 32'h0012_3456, "rd_clkdiv1");

        // IRQ flags: set, then set+W1C collision, then set+clr
        irq_set = 8'h03; tick(); irq_set = 8'h00;
        chk("irq_set",      irq_flags, 8'h03);
        chk("irq_out_mask0", irq_out,  1'b0);
        irq_set = 8'h01;
        wr(3'd1, 32'h0000_0103);
        irq_set = 8'h00;
        chk("irq_set_vs_w1c", irq_flags, 8'h01);
        chk("irq_out_mask1",  irq_out,   1'b1);
        rd(3'd1, 32'h0000_0101, "rd_irq");
        irq_set = 8'h02; irq_clr = 8'h03; tick(); irq_set = 8'h00; irq_clr = 8'h00;
        chk("irq_clr",      irq_flags, 8'h02);
        chk("irq_out_off",  irq_out,   1'b0);
        irq_clr = 8'h02; tick(); irq_clr = 8'h00;
        chk("irq_clr_all",  irq_flags, 8'h00);

`ifdef PIO_SM_CTRL_EXEC_EN
        wr(3'd0, 32'h0);
        chk("en_cleared", sm_en, 4'b0000);

        // Injection into machine 2 with three stalled penables
        sm_stalled = 4'b0100;
        wr(3'd2, 32'h0002_E001);
        chk("exec_imm",   sm_imm,    4'b0100);
        chk("exec_instr", imm_instr, 16'hE001);
        chk("exec_force_en", sm_en,  4'b0100);
        for (int i = 0; i < 3; i++) begin
            sm_penable = 4'b0100; tick(); sm_penable = '0;
            chk("stall_imm",   sm_imm,    4'b0100);
            chk("stall_instr", imm_instr, 16'hE001);
        end
        rd(3'd3, 32'h0000_0041, "rd_status_busy");
        wr(3'd2, 32'h0001_BEEF);
        chk("ovf_instr_kept", imm_instr, 16'hE001);
        chk("ovf_imm_kept",   sm_imm,    4'b0100);
        wr(3'd0, 32'h0);
        chk("force_en_wins", sm_en, 4'b0100);
        rd(3'd3, 32'h0000_0141, "rd_status_ovf");
        rd(3'd2, 32'h0000_E001, "rd_exec_last");
        sm_stalled = '0; sm_penable = 4'b0100; tick(); sm_penable = '0;
        chk("done_imm",   sm_imm,    4'b0000);
        chk("done_instr", imm_instr, 16'h0000);
        chk("done_en",    sm_en,     4'b0000);
        rd(3'd3, 32'h0000_0101, "rd_status_done");
        rd(3'd3, 32'h0000_0100, "rd_status_idle");
        wr(3'd3, 32'h0000_0100);
        rd(3'd3, 32'h0, "rd_status_ovf_clr");

        // Reset mid-injection, then a fresh injection
        wr(3'd2, 32'h0001_1234);
        chk("inj1_imm", sm_imm, 4'b0010);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_imm",   sm_imm,    4'b0000);
        chk("rst_mid_instr", imm_instr, 16'h0000);
        rd(3'd3, 32'h0, "rd_status_after_rst");
        wr(3'd2, 32'h0000_5678);
        chk("inj0_imm",   sm_imm,    4'b0001);
        chk("inj0_instr", imm_instr, 16'h5678);
        sm_penable = 4'b0001; tick(); sm_penable = '0;
        chk("inj0_done", sm_imm, 4'b0000);
        tick();

        // Restart of the target aborts the injection
        wr(3'd2, 32'h0003_AAAA);
        chk("inj3_imm", sm_imm, 4'b1000);
        wr(3'd0, 32'h0000_0080);
        chk("abort_imm",     sm_imm,     4'b0000);
        chk("abort_restart", sm_restart, 4'b1000);
        rd(3'd3, 32'h0, "rd_status_abort");
`else
        // Injection absent: EXEC is inert
        wr(3'd2, 32'h0002_E001);
        chk("noexec_imm",   sm_imm,    4'b0000);
        chk("noexec_instr", imm_instr, 16'h0000);
        chk("noexec_en",    sm_en,     4'b0101);
        rd(3'd2, 32'h0, "rd_exec_disabled");
        sm_stalled = 4'b0100;
        rd(3'd3, 32'h0000_0040, "rd_status_disabled");
        sm_stalled = '0;
        wr(3'd0, 32'h0);
        chk("noexec_en_clr", sm_en, 4'b0000);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pio_sm_ctrl.md
# pio_sm_ctrl

Host-facing control and scheduling block for a bank of PIO state machines. It owns the per-machine enable, restart and clock-divider configuration, and the shared IRQ flag register. It also arbitrates host "immediate instruction" injection into one machine at a time through a small handshake FSM. It sits between the host register bus and the `machine` instances, driving their `en`, `restart`, `div`, `imm` and `irq_flags_in` inputs.

## Interface
- NUM_SM, 4: number of state machines controlled (1..4); SM index fields are 2 bits.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clock clk
- wr_en  in  1  host register write strobe
- wr_addr  in  3  host write address
- wr_data  in  32  host write data
- rd_addr  in  3  host read address
- rd_data  out  32  registered read data, 1-cycle latency
- sm_penable  in  NUM_SM  per-machine divided-clock enable
- sm_stalled  in  NUM_SM  machine waiting/stalled this cycle
- irq_set  in  8  OR of machine IRQ-set strobes
- irq_clr  in  8  OR of machine IRQ-clear strobes
- sm_en  out  NUM_SM  machine enable
- sm_restart  out  NUM_SM  one-cycle restart pulse
- sm_div  out  24*NUM_SM  packed clock divisors, machine n at [24n+23:24n]
- sm_imm  out  NUM_SM  immediate-instruction select
- imm_instr  out  16  instruction to inject
- irq_flags  out  8  shared IRQ flags to machines
- irq_out  out  1  host interrupt: |(irq_flags[3:0] & IRQ_MASK)

## Operation
- Register map (word addresses):
  - 0 CTRL: [3:0] EN (rw); [7:4] RESTART (write-1 pulse, reads 0).
  - 1 IRQ: [7:0] flags (read), write-1-to-clear; [11:8] IRQ_MASK (rw).
  - 2 EXEC: write [15:0] instr, [17:16] target SM. Reads the last instr written.
  - 3 STATUS (read only): [0] busy; [3:0+4] sm_stalled snapshot at [7:4]; [8] EXEC_OVF sticky. Writing 1 to [8] clears EXEC_OVF.
  - 4..7 CLKDIV_n: [23:0] divisor for machine n (rw). Addresses with n ≥ NUM_SM read 0 and ignore writes.
- sm_restart[n] pulses high for exactly 1 cycle, in the cycle after a CTRL write with bit 4+n set. EN updates in the same cycle.
- IRQ flag update each cycle: flags <= (flags & ~host_w1c & ~irq_clr) | irq_set. Set has priority over both clear sources.
- Injection FSM:
  - IDLE: a write to EXEC latches instr and target, then moves to ISSUE next cycle.
  - ISSUE: sm_imm[target]=1, imm_instr=latched instr, and sm_en[target] is forced to 1.
    - Leave ISSUE on the first cycle with sm_penable[target] & !sm_stalled[target], going to DONE.
    - If stalled, hold ISSUE indefinitely; the instruction is retried on every penable.
  - DONE: outputs deasserted for one cycle, then return to IDLE.
  - busy = (state != IDLE).
- A write to EXEC while busy is dropped, sets EXEC_OVF, and leaves the latched instr unchanged.
- A CTRL restart of the target machine while in ISSUE aborts the injection: the FSM goes to IDLE next cycle.
- Target ≥ NUM_SM: the write is ignored and EXEC_OVF is set.

## Timing
- Reset values:
  - Outputs: rd_data=0, sm_en=0, sm_restart=0, sm_div=all 1 (n=1 per machine), sm_imm=0, imm_instr=0, irq_flags=0, irq_out=0.
  - Internal: FSM in IDLE, EXEC_OVF=0, IRQ_MASK=0.
- All register writes take effect on the clock edge of wr_en; outputs reflect them the following cycle.
- irq_flags updates 1 cycle after irq_set/irq_clr.
- Injection latency: the EXEC write at cycle T gives sm_imm high from T+1. Deassertion is 1 cycle after the qualifying penable edge, and busy clears 2 cycles after it.
- Simultaneous CTRL EN-clear and ISSUE on the same machine: the force-enable wins until the injection completes.
- Reset mid-injection: the FSM returns to IDLE and sm_imm=0 in the next cycle.

## Configuration
- PIO_SM_CTRL_EXEC_EN defined: the injection FSM and EXEC register are present as specified.
- PIO_SM_CTRL_EXEC_EN not defined:
  - sm_imm=0 and imm_instr=0 at all times.
  - EXEC writes are ignored; EXEC and STATUS busy/EXEC_OVF read 0.
  - sm_en equals CTRL EN only.

## Test plan
- Reset, then read all addresses: CTRL=0, IRQ=0, CLKDIV_0..3=1, STATUS=0. All outputs at their reset values.
- Write CTRL=0x0000_0025: sm_en=4'b0101 from the next cycle, and sm_restart=4'b0010 for exactly 1 cycle. CTRL then reads 0x5.
- EXEC write 0xE001 to target 2 with sm_stalled[2]=1 for 3 penables, then 0:
  - sm_imm=4'b0100 and imm_instr=0xE001 are held through the stalls.
  - Deassertion follows the first unstalled penable; busy drops 2 cycles later.
- Second EXEC write while busy: the ignored instr never appears, and STATUS[8]=1. Writing STATUS 0x100 clears it.
- irq_set=0x01 and host IRQ W1C 0x01 in the same cycle: flag bit0 stays 1. With IRQ_MASK=0x1, irq_out=1.
- Assert reset during ISSUE: sm_imm=0 next cycle, busy=0, and the next EXEC is accepted normally.
